// File: rtl/scoreboard_controller_mp.sv
// Multi-player BCD scoreboard: per-player scores, round countdown timer, shared level and leader flag.
// Segment outputs decode registered counters directly; points land two clocks after Pt rises.
module scoreboard_controller_mp #(
  parameter int NUM_PLAYERS  = 2,
  parameter int POINT_DIGITS = 3,
  parameter int TIMER_DIGITS = 2,
  parameter int ROUND_TIME   = 30,
  parameter int TICK_DIV     = 4,
  parameter int LEVEL_POINTS = 20,
  parameter int MAX_LEVEL    = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  St,
  input  logic [NUM_PLAYERS-1:0]                Pt,
  output logic                                  Done,
  output logic [NUM_PLAYERS*POINT_DIGITS*7-1:0] seg7_points,
  output logic [TIMER_DIGITS*7-1:0]             seg7_timer,
  output logic [6:0]                            seg7_level,
  output logic [((NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1)-1:0] leader,
  output logic                                  lead_valid
);

  localparam int LW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int SW = POINT_DIGITS * 4;
  localparam int TW = TIMER_DIGITS * 4;
  localparam int PW = $clog2(LEVEL_POINTS + NUM_PLAYERS + 1);
  localparam int CW = $clog2(TICK_DIV + 1);

  if (NUM_PLAYERS < 1 || NUM_PLAYERS > 4 || POINT_DIGITS < 1 || POINT_DIGITS > 4 ||
      TIMER_DIGITS < 1 || TIMER_DIGITS > 3 || ROUND_TIME < 0 || ROUND_TIME >= 10**TIMER_DIGITS ||
      TICK_DIV < 1 || LEVEL_POINTS < 1 || MAX_LEVEL < 1 || MAX_LEVEL > 9) begin : g_bad_param
    $error("scoreboard_controller_mp: parameter out of range");
  end

  function automatic logic [TW-1:0] to_bcd(input int v);
    logic [TW-1:0] r;
    int            x;
    r = '0;
    x = v;
    for (int i = 0; i < TIMER_DIGITS; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  localparam logic [TW-1:0] ROUND_BCD = to_bcd(ROUND_TIME);

  // Saturating BCD increment: all-9s holds.
  function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    logic          all9;
    logic          c;
    all9 = 1'b1;
    for (int i = 0; i < POINT_DIGITS; i++) if (v[i*4 +: 4] != 4'd9) all9 = 1'b0;
    r = v;
    c = ~all9;
    for (int i = 0; i < POINT_DIGITS; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == 4'd9) r[i*4 +: 4] = 4'd0;
        else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [TW-1:0] bcd_dec(input logic [TW-1:0] v);
    logic [TW-1:0] r;
    logic          b;
    r = v;
    b = (v != '0);
    for (int i = 0; i < TIMER_DIGITS; i++) begin
      if (b) begin
        if (r[i*4 +: 4] == 4'd0) r[i*4 +: 4] = 4'd9;
        else begin
          r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 7'h3F;  4'd1: seg = 7'h06;  4'd2: seg = 7'h5B;  4'd3: seg = 7'h4F;
      4'd4: seg = 7'h66;  4'd5: seg = 7'h6D;  4'd6: seg = 7'h7D;  4'd7: seg = 7'h07;
      4'd8: seg = 7'h7F;  4'd9: seg = 7'h6F;  default: seg = 7'h00;
    endcase
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [SW-1:0]          score_q [NUM_PLAYERS];
  logic [SW-1:0]          score_d [NUM_PLAYERS];
  logic [TW-1:0]          timer_q, timer_d;
  logic [3:0]             level_q, level_d;
  logic [PW-1:0]          lpts_q, lpts_d;
  logic [CW-1:0]          tick_q, tick_d;
  logic [NUM_PLAYERS-1:0] pt_q, pt_prev_q, pt_edge;
  logic [LW-1:0]          leader_q, leader_d;
  logic                   lead_valid_q, lead_valid_d;
  logic [PW-1:0]          pts_sum;
  logic                   expire;

  assign pt_edge = pt_q & ~pt_prev_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    level_d = level_q;
    lpts_d  = lpts_q;
    tick_d  = tick_q;
    for (int p = 0; p < NUM_PLAYERS; p++) score_d[p] = score_q[p];
    expire  = 1'b0;
    pts_sum = lpts_q;
    for (int p = 0; p < NUM_PLAYERS; p++) if (pt_edge[p]) pts_sum = pts_sum + PW'(1);

    case (state_q)
      S_IDLE:  if (St) state_d = S_ARMED;
      S_ARMED: if (!St) state_d = S_RUN;
      S_RUN: begin
        if (St) state_d = S_ARMED;
        else begin
          for (int p = 0; p < NUM_PLAYERS; p++) if (pt_edge[p]) score_d[p] = bcd_inc(score_q[p]);
          if (tick_q == CW'(TICK_DIV - 1)) begin
            tick_d  = '0;
            timer_d = bcd_dec(timer_q);
            expire  = (timer_d == '0);
          end else begin
            tick_d = tick_q + CW'(1);
          end
          // Level-up overrides an expiry on the same edge by reloading the timer.
          if (pts_sum >= PW'(LEVEL_POINTS)) begin
            if (level_q < 4'(MAX_LEVEL)) begin
              level_d = level_q + 4'd1;
              lpts_d  = '0;
              timer_d = ROUND_BCD;
              tick_d  = '0;
            end else begin
              lpts_d  = PW'(LEVEL_POINTS);
              state_d = S_DONE;
            end
          end else begin
            lpts_d = pts_sum;
            if (expire) state_d = S_DONE;
          end
        end
      end
      S_DONE:  if (St) state_d = S_ARMED;
      default: state_d = S_IDLE;
    endcase

    // Clearing on entry as well as while armed makes a restart visible on the St edge itself.
    if (state_d == S_ARMED || state_q == S_ARMED) begin
      for (int p = 0; p < NUM_PLAYERS; p++) score_d[p] = '0;
      timer_d = ROUND_BCD;
      level_d = 4'd1;
      lpts_d  = '0;
      tick_d  = '0;
    end
  end

  always_comb begin
    logic [SW-1:0] best;
    int            ntop;
    best     = score_q[0];
    leader_d = '0;
    ntop     = 0;
    for (int p = 1; p < NUM_PLAYERS; p++) begin
      if (score_q[p] > best) begin
        best     = score_q[p];
        leader_d = LW'(p);
      end
    end
    for (int p = 0; p < NUM_PLAYERS; p++) if (score_q[p] == best) ntop = ntop + 1;
    lead_valid_d = (ntop == 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      for (int p = 0; p < NUM_PLAYERS; p++) score_q[p] <= '0;
      timer_q      <= ROUND_BCD;
      level_q      <= 4'd1;
      lpts_q       <= '0;
      tick_q       <= '0;
      pt_q         <= '0;
      pt_prev_q    <= '0;
      leader_q     <= '0;
      lead_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      for (int p = 0; p < NUM_PLAYERS; p++) score_q[p] <= score_d[p];
      timer_q      <= timer_d;
      level_q      <= level_d;
      lpts_q       <= lpts_d;
      tick_q       <= tick_d;
      pt_q         <= Pt;
      pt_prev_q    <= pt_q;
      leader_q     <= leader_d;
      lead_valid_q <= lead_valid_d;
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_pseg
    for (genvar d = 0; d < POINT_DIGITS; d++) begin : g_dig
      assign seg7_points[(p*POINT_DIGITS+d)*7 +: 7] = seg(score_q[p][d*4 +: 4]);
    end
  end
  for (genvar d = 0; d < TIMER_DIGITS; d++) begin : g_tseg
    assign seg7_timer[d*7 +: 7] = seg(timer_q[d*4 +: 4]);
  end

  assign seg7_level = seg(level_q);
  assign Done       = (state_q == S_DONE);
  assign leader     = leader_q;
  assign lead_valid = lead_valid_q;

endmodule
